// File: rtl/mult_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared FSM state encoding and sizing helper for mult_seq.
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // One extra bit so the iteration counter never wraps inside an operation.
  function automatic int cnt_bits(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_if
// Purpose  : Start/result handshake between a requester and mult_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface mult_seq_if #(
  parameter int width = 32
);

  logic             valid;
  logic [width-1:0] left;
  logic [width-1:0] right;
  logic [width-1:0] out;
  logic             ready;

  modport master (
    output valid, left, right,
    input  out, ready
  );

  modport slave (
    input  valid, left, right,
    output out, ready
  );

endinterface
`default_nettype wire

// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq
// Purpose  : Iterative shift-add multiplier returning the low width bits of
//            left*right after exactly width iteration cycles, with a
//            single-cycle ready pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq
  import mult_pkg::*;
#(
  parameter int width = 32
) (
  input  wire        clk,
  input  wire        reset,
  mult_seq_if.slave  bus
);

  localparam int CW = cnt_bits(width);

  mult_state_t      state_q,  state_d;
  logic [width-1:0] acc_q,    acc_d;
  logic [width-1:0] mcand_q,  mcand_d;
  logic [width-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [width-1:0] out_q,    out_d;
  logic [width-1:0] acc_step;

  // Conditional add of the shifted multiplicand for the current multiplier bit.
  always_comb begin
    acc_step = acc_q;
    if (mplier_q[0]) begin
      acc_step = acc_q + mcand_q;
    end
  end

  // Next-state and datapath update; operands are captured only in IDLE/DONE.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    out_d    = out_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.valid) begin
          mcand_d  = bus.left;
          mplier_d = bus.right;
          acc_d    = '0;
          count_d  = '0;
          state_d  = BUSY;
        end else begin
          state_d  = IDLE;
        end
      end
      BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        // The last iteration's add is folded straight into the result.
        if (count_q == CW'(width - 1)) begin
          out_d   = acc_step;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in flight without a pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      out_q    <= out_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.ready = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq
// Purpose  : Directed self-checking bench for mult_seq (width = 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_seq;

  localparam int W = 32;

  logic clk;
  logic rst_n;

  mult_seq_if #(.width(W)) bus ();

  mult_seq #(.width(W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int vectors;
  int miscompares;
  int lat;
  logic [W-1:0] res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation and reports edges-after-start until ready (-1 on timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int l, output logic [W-1:0] r);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.left  = a;
    bus.right = b;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    l = -1;
    r = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.ready === 1'b1) begin
        l = k;
        r = bus.out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.valid = 1'b1;
    bus.left  = 32'd11;
    bus.right = 32'd13;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 0", bus.ready);
    end
    vectors++;
    if (bus.out !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_out: got %h expected 0", bus.out);
    end
    @(negedge clk);
    bus.valid = 1'b0;
    rst_n     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.ready !== 1'b0 || bus.out !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_release: got ready=%b out=%h expected ready=0 out=0",
               bus.ready, bus.out);
    end
  endtask

  task automatic test_basic();
    run_op(32'd3, 32'd5, lat, res);
    vectors++;
    if (lat !== 32) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d expected 32", lat);
    end
    vectors++;
    if (res !== 32'd15) begin
      miscompares++;
      $display("FAIL basic_out: got %0d expected 15", res);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_pulse: got ready=%b expected 0", bus.ready);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.out !== 32'd15) begin
      miscompares++;
      $display("FAIL basic_hold: got %0d expected 15", bus.out);
    end
  endtask

  task automatic test_overflow();
    run_op(32'hFFFF_FFFF, 32'd2, lat, res);
    vectors++;
    if (lat !== 32 || res !== 32'hFFFF_FFFE) begin
      miscompares++;
      $display("FAIL ovf_ffff_x2: got lat=%0d out=%h expected lat=32 out=fffffffe", lat, res);
    end
    run_op(32'hFFFF_FFFD, 32'd4, lat, res);
    vectors++;
    if (lat !== 32 || res !== 32'hFFFF_FFF4) begin
      miscompares++;
      $display("FAIL signed_m3_x4: got lat=%0d out=%h expected lat=32 out=fffffff4", lat, res);
    end
    run_op(32'h0001_0001, 32'h0001_0001, lat, res);
    vectors++;
    if (res !== 32'h0002_0001) begin
      miscompares++;
      $display("FAIL wrap_10001sq: got %h expected 00020001", res);
    end
  endtask

  task automatic test_zero();
    run_op(32'd0, 32'd0, lat, res);
    vectors++;
    if (lat !== 32) begin
      miscompares++;
      $display("FAIL zero_latency: got %0d expected 32", lat);
    end
    vectors++;
    if (res !== 32'd0) begin
      miscompares++;
      $display("FAIL zero_out: got %h expected 0", res);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int first_k;
    @(negedge clk);
    bus.valid = 1'b1;
    bus.left  = 32'd7;
    bus.right = 32'd6;
    @(posedge clk);
    #1;
    bus.left  = 32'd9;
    bus.right = 32'd9;
    pulses  = 0;
    first_k = -1;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      if (bus.ready === 1'b1) begin
        pulses++;
        if (first_k < 0) begin
          first_k = k;
          res     = bus.out;
        end
      end
    end
    vectors++;
    if (pulses !== 1 || first_k !== 32) begin
      miscompares++;
      $display("FAIL b2b_first_pulse: got pulses=%0d at=%0d expected 1 at 32", pulses, first_k);
    end
    vectors++;
    if (res !== 32'd42) begin
      miscompares++;
      $display("FAIL b2b_first_out: got %0d expected 42", res);
    end
    // valid stayed high through DONE, so 9*9 is captured on this edge.
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    vectors++;
    if (bus.ready !== 1'b0 || bus.out !== 32'd42) begin
      miscompares++;
      $display("FAIL b2b_restart: got ready=%b out=%0d expected ready=0 out=42",
               bus.ready, bus.out);
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.ready === 1'b1) begin
        lat = k;
        res = bus.out;
        break;
      end
    end
    vectors++;
    if (lat !== 32) begin
      miscompares++;
      $display("FAIL b2b_second_latency: got %0d expected 32", lat);
    end
    vectors++;
    if (res !== 32'd81) begin
      miscompares++;
      $display("FAIL b2b_second_out: got %0d expected 81", res);
    end
  endtask

  task automatic test_abort();
    int pulses;
    @(negedge clk);
    bus.valid = 1'b1;
    bus.left  = 32'd100;
    bus.right = 32'd100;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out !== 32'd0) begin
      miscompares++;
      $display("FAIL abort_out: got %h expected 0", bus.out);
    end
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_ready: got %b expected 0", bus.ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.ready === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL abort_no_pulse: got %0d pulses expected 0", pulses);
    end
    run_op(32'd2, 32'd2, lat, res);
    vectors++;
    if (lat !== 32 || res !== 32'd4) begin
      miscompares++;
      $display("FAIL abort_recover: got lat=%0d out=%0d expected lat=32 out=4", lat, res);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.valid   = 1'b0;
    bus.left    = '0;
    bus.right   = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_zero();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
